// File: rtl/rx_controller.sv
// UART receive controller: line-state FSM (disabled/run/resync/break), receive FIFO and error
// counters. Define RX_CONTROLLER_PARITY_DROP_EN to discard characters received with a parity error.
module rx_controller #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 rx_i,
    input  logic                 clear_i,
    output logic                 rec_rst_o,
    input  logic [DATA_BITS-1:0] rec_char_i,
    input  logic                 rec_valid_i,
    input  logic                 rec_frame_error_i,
    input  logic                 rec_parity_error_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 perr_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 overrun_o,
    output logic                 break_o,
    output logic [7:0]           frame_err_cnt_o,
    output logic [7:0]           parity_err_cnt_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
`ifdef RX_CONTROLLER_PARITY_DROP_EN
    localparam int unsigned EW = DATA_BITS;
`else
    localparam int unsigned EW = DATA_BITS + 1;
`endif

    typedef enum logic [1:0] {StDisabled, StRun, StResync, StBreak} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [IW-1:0]   r_idle_cnt;
    logic [IW-1:0]   w_idle_cnt_next;

    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            r_overrun;
    logic [7:0]      r_frame_cnt;
    logic [7:0]      r_parity_cnt;

    logic            w_in_run;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_overrun_set;
    logic [EW-1:0]   w_entry;
    logic [EW-1:0]   w_head;

    // Line-state FSM: the idle counter is only meaningful in resync/break.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StDisabled;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idle_cnt <= w_idle_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_idle_cnt_next = r_idle_cnt;
        if (!enable_i) begin
            w_state_next    = StDisabled;
            w_idle_cnt_next = '0;
        end else begin
            case (r_state)
                StDisabled: begin
                    w_state_next    = StRun;
                    w_idle_cnt_next = '0;
                end
                StRun: begin
                    w_idle_cnt_next = '0;
                    if (rec_frame_error_i) begin
                        w_state_next = (rec_char_i == '0) ? StBreak : StResync;
                    end
                end
                StResync, StBreak: begin
                    if (!rx_i) begin
                        w_idle_cnt_next = '0;
                    end else if (r_idle_cnt == IW'(IDLE_CYCLES - 1)) begin
                        w_state_next    = StRun;
                        w_idle_cnt_next = '0;
                    end else begin
                        w_idle_cnt_next = r_idle_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next    = StDisabled;
                    w_idle_cnt_next = '0;
                end
            endcase
        end
    end

    assign w_in_run  = (r_state == StRun);
    assign rec_rst_o = !w_in_run;
    assign break_o   = (r_state == StBreak);

`ifdef RX_CONTROLLER_PARITY_DROP_EN
    assign w_push_req = w_in_run && rec_valid_i && !rec_parity_error_i;
    assign w_entry    = rec_char_i;
    assign perr_o     = 1'b0;
    assign data_o     = w_head;
`else
    assign w_push_req = w_in_run && (rec_valid_i || rec_parity_error_i);
    assign w_entry    = {rec_parity_error_i, rec_char_i};
    assign perr_o     = w_head[DATA_BITS];
    assign data_o     = w_head[DATA_BITS-1:0];
`endif

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_empty       = (r_wptr == r_rptr);
    assign w_full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop         = !w_empty && data_ready_i;
    assign w_push        = w_push_req && (!w_full || w_pop);
    assign w_overrun_set = w_push_req && w_full && !w_pop;
    assign w_head        = r_mem[r_rptr[AW-1:0]];
    assign data_valid_o  = !w_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // A fresh overrun wins over a clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (clear_i) begin
            r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_frame_cnt  <= '0;
            r_parity_cnt <= '0;
        end else begin
            if (w_in_run && rec_frame_error_i && (r_frame_cnt != 8'hFF)) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_in_run && rec_parity_error_i && (r_parity_cnt != 8'hFF)) begin
                r_parity_cnt <= r_parity_cnt + 8'd1;
            end
        end
    end

    assign overrun_o        = r_overrun;
    assign frame_err_cnt_o  = r_frame_cnt;
    assign parity_err_cnt_o = r_parity_cnt;

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller: a vector table for FIFO/overrun/clear behaviour followed by
// hand-written sequences for idle resync, break, parity, saturation, disable and reset.
module tb_rx_controller;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx;
    logic       clr;
    logic       rec_rst;
    logic [7:0] ch;
    logic       valid;
    logic       fe;
    logic       pe;
    logic [7:0] data;
    logic       perr;
    logic       dv;
    logic       ready;
    logic       ovr;
    logic       brk;
    logic [7:0] fcnt;
    logic [7:0] pcnt;

    int n_total = 0;
    int n_bad   = 0;

    rx_controller #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .IDLE_CYCLES(16)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (en),
        .rx_i              (rx),
        .clear_i           (clr),
        .rec_rst_o         (rec_rst),
        .rec_char_i        (ch),
        .rec_valid_i       (valid),
        .rec_frame_error_i (fe),
        .rec_parity_error_i(pe),
        .data_o            (data),
        .perr_o            (perr),
        .data_valid_o      (dv),
        .data_ready_i      (ready),
        .overrun_o         (ovr),
        .break_o           (brk),
        .frame_err_cnt_o   (fcnt),
        .parity_err_cnt_o  (pcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rst, en, rx, clr, valid, fe, pe;
        logic [7:0] ch;
        logic       ready;
        logic       e_rec_rst, e_dv;
        logic [7:0] e_data;
        logic       e_perr, e_ovr, e_brk;
        logic [7:0] e_fcnt, e_pcnt;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic r, e, x, c, v, f, p, input logic [7:0] h,
                                input logic rd, erst, edv, input logic [7:0] edata,
                                input logic eperr, eovr, ebrk, input logic [7:0] ef, ep);
        vec_t t;
        t.rst = r;  t.en = e;  t.rx = x;  t.clr = c;  t.valid = v;  t.fe = f;  t.pe = p;
        t.ch = h;   t.ready = rd;
        t.e_rec_rst = erst;  t.e_dv = edv;  t.e_data = edata;  t.e_perr = eperr;
        t.e_ovr = eovr;  t.e_brk = ebrk;  t.e_fcnt = ef;  t.e_pcnt = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr = 0; valid = 0; fe = 0; pe = 0; ch = 8'h00;
    endtask

    initial begin
        //              rst en rx clr vl fe pe ch     rdy  rrst dv data  pe ov bk f      p
        vecs[0]  = mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 8'd0, 8'd0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0, 0, 8'd0, 8'd0);
        vecs[2]  = mk(0, 1, 1, 0, 1, 0, 0, 8'hA5, 1,   0, 1, 8'hA5, 0, 0, 0, 8'd0, 8'd0);
        vecs[3]  = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0, 0, 8'd0, 8'd0);
        vecs[4]  = mk(0, 1, 1, 0, 1, 0, 0, 8'h01, 0,   0, 1, 8'h01, 0, 0, 0, 8'd0, 8'd0);
        vecs[5]  = mk(0, 1, 1, 0, 1, 0, 0, 8'h02, 0,   0, 1, 8'h01, 0, 0, 0, 8'd0, 8'd0);
        vecs[6]  = mk(0, 1, 1, 0, 1, 0, 0, 8'h03, 0,   0, 1, 8'h01, 0, 0, 0, 8'd0, 8'd0);
        vecs[7]  = mk(0, 1, 1, 0, 1, 0, 0, 8'h04, 0,   0, 1, 8'h01, 0, 0, 0, 8'd0, 8'd0);
        vecs[8]  = mk(0, 1, 1, 0, 1, 0, 0, 8'h05, 0,   0, 1, 8'h01, 0, 1, 0, 8'd0, 8'd0);
        vecs[9]  = mk(0, 1, 1, 0, 1, 0, 0, 8'h06, 1,   0, 1, 8'h02, 0, 1, 0, 8'd0, 8'd0);
        vecs[10] = mk(0, 1, 1, 1, 0, 0, 0, 8'h00, 0,   0, 1, 8'h02, 0, 0, 0, 8'd0, 8'd0);
        vecs[11] = mk(0, 1, 1, 1, 1, 0, 0, 8'h07, 0,   0, 1, 8'h02, 0, 1, 0, 8'd0, 8'd0);
        vecs[12] = mk(0, 1, 1, 1, 0, 0, 0, 8'h00, 0,   0, 1, 8'h02, 0, 0, 0, 8'd0, 8'd0);
        vecs[13] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1,   0, 1, 8'h03, 0, 0, 0, 8'd0, 8'd0);
        vecs[14] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1,   0, 1, 8'h04, 0, 0, 0, 8'd0, 8'd0);
        vecs[15] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1,   0, 1, 8'h06, 0, 0, 0, 8'd0, 8'd0);
        vecs[16] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0, 0, 8'd0, 8'd0);
        vecs[17] = mk(0, 1, 0, 0, 0, 1, 0, 8'h55, 1,   1, 0, 8'h00, 0, 0, 0, 8'd1, 8'd0);
        vecs[18] = mk(0, 1, 0, 0, 1, 1, 1, 8'h11, 1,   1, 0, 8'h00, 0, 0, 0, 8'd1, 8'd0);
        vecs[19] = mk(0, 1, 0, 1, 0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 0, 0, 8'd0, 8'd0);

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst;  en = vecs[i].en;  rx = vecs[i].rx;  clr = vecs[i].clr;
            valid = vecs[i].valid;  fe = vecs[i].fe;  pe = vecs[i].pe;  ch = vecs[i].ch;
            ready = vecs[i].ready;
            step();
            chk($sformatf("v%0d rec_rst", i), 32'(rec_rst), 32'(vecs[i].e_rec_rst));
            chk($sformatf("v%0d data_valid", i), 32'(dv), 32'(vecs[i].e_dv));
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d data", i), 32'(data), 32'(vecs[i].e_data));
                chk($sformatf("v%0d perr", i), 32'(perr), 32'(vecs[i].e_perr));
            end
            chk($sformatf("v%0d overrun", i), 32'(ovr), 32'(vecs[i].e_ovr));
            chk($sformatf("v%0d break", i), 32'(brk), 32'(vecs[i].e_brk));
            chk($sformatf("v%0d frame_cnt", i), 32'(fcnt), 32'(vecs[i].e_fcnt));
            chk($sformatf("v%0d parity_cnt", i), 32'(pcnt), 32'(vecs[i].e_pcnt));
        end

        // Resync: 16 idle cycles back to run.
        idle_inputs();
        rx = 1;
        for (int i = 0; i < 15; i++) step();
        chk("resync 15 idle rec_rst", 32'(rec_rst), 32'd1);
        step();
        chk("resync 16 idle rec_rst", 32'(rec_rst), 32'd0);

        // Break, with an interrupted idle run.
        fe = 1; ch = 8'h00;
        step();
        idle_inputs();
        chk("break entry break_o", 32'(brk), 32'd1);
        chk("break entry rec_rst", 32'(rec_rst), 32'd1);
        chk("break entry frame_cnt", 32'(fcnt), 32'd1);
        rx = 1;
        for (int i = 0; i < 15; i++) step();
        chk("break 15 ones", 32'(brk), 32'd1);
        rx = 0;
        step();
        chk("break glitch", 32'(brk), 32'd1);
        rx = 1;
        for (int i = 0; i < 15; i++) step();
        chk("break 15 more ones", 32'(brk), 32'd1);
        step();
        chk("break exit break_o", 32'(brk), 32'd0);
        chk("break exit rec_rst", 32'(rec_rst), 32'd0);

        // Parity error character.
        ready = 0; pe = 1; ch = 8'h3C;
        step();
        idle_inputs();
        chk("parity cnt", 32'(pcnt), 32'd1);
`ifdef RX_CONTROLLER_PARITY_DROP_EN
        chk("parity drop data_valid", 32'(dv), 32'd0);
`else
        chk("parity push data_valid", 32'(dv), 32'd1);
        chk("parity push data", 32'(data), 32'h3C);
        chk("parity push perr", 32'(perr), 32'd1);
`endif
        ready = 1;
        step();
        chk("parity drained", 32'(dv), 32'd0);

        // Frame error counter saturation.
        clr = 1;
        step();
        clr = 0;
        chk("clear frame_cnt", 32'(fcnt), 32'd0);
        chk("clear parity_cnt", 32'(pcnt), 32'd0);
        rx = 1;
        for (int i = 0; i < 300; i++) begin
            fe = 1; ch = 8'h5A;
            step();
            fe = 0;
            for (int k = 0; k < 16; k++) step();
            if (i == 9) chk("frame_cnt after 10", 32'(fcnt), 32'd10);
        end
        chk("frame_cnt saturated", 32'(fcnt), 32'd255);
        chk("running after errors", 32'(rec_rst), 32'd0);

        // Disable with buffered data.
        ready = 0; valid = 1; ch = 8'h41;
        step();
        ch = 8'h42;
        step();
        valid = 0; en = 0;
        step();
        chk("disable rec_rst", 32'(rec_rst), 32'd1);
        chk("disable data_valid", 32'(dv), 32'd1);
        chk("disable head", 32'(data), 32'h41);
        valid = 1; ch = 8'h99; ready = 1;
        step();
        valid = 0;
        chk("disabled pop head", 32'(data), 32'h42);
        step();
        chk("disabled drained", 32'(dv), 32'd0);
        chk("disabled still rec_rst", 32'(rec_rst), 32'd1);

        // Reset in the middle of a break discards everything.
        en = 1; ready = 0;
        step();
        valid = 1; ch = 8'h77;
        step();
        valid = 0; fe = 1; ch = 8'h00;
        step();
        chk("pre-reset break", 32'(brk), 32'd1);
        rst = 1; fe = 1; valid = 1; pe = 1; rx = 1;
        step();
        idle_inputs();
        chk("reset rec_rst", 32'(rec_rst), 32'd1);
        chk("reset data_valid", 32'(dv), 32'd0);
        chk("reset break", 32'(brk), 32'd0);
        chk("reset overrun", 32'(ovr), 32'd0);
        chk("reset frame_cnt", 32'(fcnt), 32'd0);
        chk("reset parity_cnt", 32'(pcnt), 32'd0);
        step();
        chk("post-reset rec_rst", 32'(rec_rst), 32'd0);
        chk("post-reset data_valid", 32'(dv), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_controller.md
RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, width of received character.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter IDLE_CYCLES, default 16, consecutive rx_i-high cycles required to leave RESYNC/BREAK.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset.
REQ-005 SHALL have ports: enable_i in 1 receiver enable; rx_i in 1 synchronized serial line (idle monitor); clear_i in 1 clear error status.
REQ-006 SHALL have ports: rec_rst_o out 1 reset to character_recovery; rec_char_i in DATA_BITS; rec_valid_i in 1; rec_frame_error_i in 1; rec_parity_error_i in 1.
REQ-007 SHALL have ports: data_o out DATA_BITS; perr_o out 1 parity flag of head entry; data_valid_o out 1; data_ready_i in 1.
REQ-008 SHALL have ports: overrun_o out 1 sticky; break_o out 1; frame_err_cnt_o out 8; parity_err_cnt_o out 8.

Function
REQ-009 SHALL implement FSM states DISABLED, RUN, RESYNC, BREAK; rec_rst_o=1 in all states except RUN.
REQ-010 DISABLED: enable_i=1 -> RUN next cycle.
REQ-011 Any state: enable_i=0 -> DISABLED next cycle; FIFO contents retained.
REQ-012 RUN: rec_frame_error_i with rec_char_i==0 -> BREAK; rec_frame_error_i with nonzero char -> RESYNC.
REQ-013 RESYNC/BREAK: idle counter counts consecutive rx_i=1 cycles, resets to 0 on rx_i=0; reaching IDLE_CYCLES -> RUN next cycle.
REQ-014 break_o SHALL be 1 exactly while state is BREAK.
REQ-015 rec_valid_i, rec_frame_error_i, rec_parity_error_i SHALL be ignored outside RUN.
REQ-016 RUN: rec_valid_i=1 SHALL push {rec_char_i, perr=0}; latency push to data_valid_o (empty FIFO) = 1 cycle.
REQ-017 Stream: pop occurs when data_valid_o && data_ready_i; data_o/perr_o stable while data_valid_o && !data_ready_i.
REQ-018 Push when full and no pop SHALL drop the character and set overrun_o; push and pop same cycle when full SHALL both occur, no overrun.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by extra pointer bit.
REQ-020 frame_err_cnt_o increments on each RUN-state rec_frame_error_i (break included); parity_err_cnt_o on each RUN-state rec_parity_error_i; both saturate at 255.
REQ-021 clear_i SHALL zero both counters (clear beats increment same cycle) and clear overrun_o (new overrun beats clear same cycle).

Reset
REQ-022 rst_i SHALL force state DISABLED, rec_rst_o=1, FIFO empty, data_valid_o=0, overrun_o=0, break_o=0, counters 0, idle counter 0; reset beats all other inputs.
REQ-023 rst_i mid-character or mid-BREAK SHALL discard all state; no output except rec_rst_o asserted first cycle after release.

Configuration
REQ-024 Macro RX_CONTROLLER_PARITY_DROP_EN defined: characters with rec_parity_error_i in RUN SHALL NOT be pushed; perr_o tied 0.
REQ-025 Macro undefined: such characters SHALL be pushed with perr=1 (rec_valid_i or rec_parity_error_i triggers push); counting unchanged in both builds.

Verification
REQ-026 Reset, enable_i=1, rec_valid_i pulse char 0xA5, data_ready_i=1 -> rec_rst_o=0 from cycle 1, data_valid_o=1 with data_o=0xA5 one cycle after pulse, then 0.
REQ-027 data_ready_i=0, push 5 chars 0x01..0x05 (depth 4) -> overrun_o=1, FIFO holds 0x01..0x04; clear_i -> overrun_o=0, counters 0.
REQ-028 rec_frame_error_i with char 0x00 -> break_o=1, rec_rst_o=1, frame_err_cnt_o=1; rx_i=1 for 15 cycles, one 0, then 16 ones -> RUN after 16th.
REQ-029 rec_parity_error_i char 0x3C -> parity_err_cnt_o=1; with macro no push; without macro data_o=0x3C, perr_o=1.
REQ-030 300 frame errors with rx_i held high -> frame_err_cnt_o saturates 255; enable_i=0 mid-stream -> DISABLED, rec_rst_o=1 next cycle, buffered data still poppable.
